seed_hit_scanner: RTL and testbench
===================================

Name: seed_hit_scanner

Overview:
- Parametrised seed-hit detector for the BLAST pipeline. It holds one query sequence and streams database bases (2-bit encoded, one base per beat) through a W-base sliding window.
- Each cycle the window is compared against every query offset in parallel. Every match is reported, not only the first.
- Matches are drained one per cycle, lowest query offset first, as (query position, database position) pairs on a valid/ready hit stream to the downstream extension stage.

Parameters:
- QUERY_BASES, 256, query length in bases (query bus = 2*QUERY_BASES bits)
- W, 11, seed word length in bases (2 <= W <= QUERY_BASES)
- DPOS_W, 32, width of database position counter
- QPOS_W, $clog2(QUERY_BASES), width of query position output
- CNT_W, 16, width of hit counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- query  in  2*QUERY_BASES  query bases; base i occupies bits [2i+1:2i]
- query_load  in  1  capture query and restart scan
- db_base  in  2  database base
- db_valid  in  1  db_base valid
- db_ready  out  1  block accepts db_base this cycle
- db_last  in  1  with accepted beat: last base of current database sequence
- hit_valid  out  1  hit pair valid
- hit_ready  in  1  downstream accepts hit
- hit_qpos  out  QPOS_W  query offset of seed start
- hit_dpos  out  DPOS_W  database offset of seed start
- hit_count  out  CNT_W  total hits emitted since last query_load, saturating
- busy  out  1  pending matches not yet drained

Behaviour:
- Reset values:
  - State NOQUERY.
  - db_ready=0, hit_valid=0, hit_qpos=0, hit_dpos=0, hit_count=0, busy=0.
  - Window, fill counter, position counter and pending mask all cleared.
- Definitions:
  - NP = QUERY_BASES-W+1 compare offsets.
  - pend[NP-1:0] is the pending match mask.
  - fill counts the valid bases in the window, saturating at W.
  - dcnt is the number of bases accepted in the current database sequence.
- States:
  - NOQUERY: db_ready=0. query_load -> SCAN.
  - SCAN: pend==0. db_ready=1.
  - DRAIN: pend!=0. db_ready=1 only when pend has exactly one set bit and hit_ready=1, so the last pop and the next accept share a cycle.
- Accept (db_valid & db_ready):
  - Window shifts in db_base as its newest base; dcnt increments, wrapping modulo 2^DPOS_W.
  - When the new fill count equals W, the new window is compared against all NP query offsets combinationally, and the result is registered into pend.
  - Offset p matches when query bases p..p+W-1 equal window oldest..newest.
  - The window start position dstart = dcnt_before_accept - (W-1), modulo 2^DPOS_W, is registered alongside pend.
  - Non-zero result -> DRAIN; zero result -> stay in SCAN.
- Latency: first hit of a window has hit_valid=1 the cycle after the accepting edge.
- Drain:
  - hit_qpos = index of the lowest set bit of pend; hit_dpos = registered dstart.
  - When hit_valid & hit_ready, that bit clears and hit_count increments, saturating at all-ones.
  - When pend becomes 0 the state returns to SCAN.
  - hit_valid and hit outputs hold stable while hit_ready=0.
- db_last: after the accepted beat is processed, fill and dcnt clear, so no seed spans two database sequences. Matches already pending still drain.
- query_load in any state, including mid-drain:
  - Captures query; clears pend, window, fill, dcnt and hit_count; state -> SCAN.
  - An input beat in the same cycle is dropped: db_ready=0 that cycle.
- Simultaneous query_load and rst: rst wins.
- Fewer than W bases since a sequence start never produce a compare.

Decomposition:
- Shared package seed_pkg: 2-bit base encoding constants (A=0, C=1, G=2, T=3), state enum {NOQUERY, SCAN, DRAIN}, and the hit pair struct {qpos, dpos}.
- One natural sub-module: lowest_set_bit_encoder (NP-bit one-hot priority encoder, outputs index and a single-bit flag), reused by other stages.

Test Plan:
- Setup for all tests: W=4, QUERY_BASES=16.
- Single hit: query = ACGT followed by 12 T; stream ACGT -> after the 4th accept, hit_valid=1 next cycle, hit_qpos=0, hit_dpos=0, hit_count=1.
- Multiple hits, ordered drain: query AAAAAAAA... (all A), stream 4 A -> 13 hits, qpos 0..12 in ascending order, one per cycle with hit_ready=1. db_ready is low for 12 cycles and rises with the 13th pop.
- Backpressure: same as the previous test with hit_ready held 0 for 5 cycles -> hit_qpos stays 0 and hit_valid stays 1; no db beats are accepted; the drain then resumes unchanged.
- Sequence boundary: stream AC with db_last on C, then GT -> no hit (fill restarted). Then stream ACGT -> hit with hit_dpos=2.
- Mid-drain query_load: during the drain in the multiple-hits test, pulse query_load -> hit_valid=0 next cycle, hit_count=0, state SCAN, and the beat offered that cycle is not accepted.
- Reset and no-query: after rst with db_valid=1 -> db_ready=0 until query_load. Counter wrap with DPOS_W=4: stream 18 bases with a match at the end -> hit_dpos=(17-3) mod 16 = 14.

Source files
------------

// File: rtl/seed_pkg.sv
// Shared types for the seed-hit stage: base encoding, scanner states and
// the (query, database) position pair handed to the extension stage.
package seed_pkg;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  typedef enum logic [1:0] {
    NOQUERY = 2'd0,
    SCAN    = 2'd1,
    DRAIN   = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [15:0] qpos;
    logic [31:0] dpos;
  } hit_pair_t;

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Priority encoder: index of the lowest set bit of vec_i, plus a flag that
// any bit is set. Index is zero when nothing is set.
module lowest_set_bit_encoder #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seed_hit_scanner.sv
// Streams database bases through a W-base window, compares it against every
// query offset at once and drains all matches lowest offset first.
module seed_hit_scanner
  import seed_pkg::*;
#(
  parameter int QUERY_BASES = 256,
  parameter int W           = 11,
  parameter int DPOS_W      = 32,
  parameter int QPOS_W      = $clog2(QUERY_BASES),
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*QUERY_BASES-1:0] query,
  input  logic                     query_load,
  input  logic [1:0]               db_base,
  input  logic                     db_valid,
  output logic                     db_ready,
  input  logic                     db_last,
  output logic                     hit_valid,
  input  logic                     hit_ready,
  output logic [QPOS_W-1:0]        hit_qpos,
  output logic [DPOS_W-1:0]        hit_dpos,
  output logic [CNT_W-1:0]         hit_count,
  output logic                     busy
);

  localparam int NP     = QUERY_BASES - W + 1;
  localparam int FILL_W = $clog2(W + 1);

  scan_state_e              state_q, state_d;
  logic [2*QUERY_BASES-1:0] query_q, query_d;
  logic [2*W-1:0]           win_q, win_d;
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic [DPOS_W-1:0]        dcnt_q, dcnt_d;
  logic [DPOS_W-1:0]        dstart_q, dstart_d;
  logic [NP-1:0]            pend_q, pend_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  // Window base 0 is the oldest; a new base enters at the top.
  logic [2*W-1:0]    win_shift;
  logic [FILL_W-1:0] fill_inc;
  logic [NP-1:0]     cmp;
  logic [NP-1:0]     pend_low_cleared;
  logic [QPOS_W-1:0] lsb_idx;
  logic              lsb_found;
  logic              pend_single;

  assign win_shift        = {db_base, win_q[2*W-1:2]};
  assign fill_inc         = (fill_q == FILL_W'(W)) ? fill_q : fill_q + FILL_W'(1);
  assign pend_low_cleared = pend_q & (pend_q - NP'(1));
  assign pend_single      = lsb_found && (pend_low_cleared == '0);

  for (genvar gi = 0; gi < NP; gi++) begin : g_cmp
    assign cmp[gi] = (query_q[2*gi +: 2*W] == win_shift);
  end

  lowest_set_bit_encoder #(
    .N     (NP),
    .IDX_W (QPOS_W)
  ) u_lsb (
    .vec_i   (pend_q),
    .idx_o   (lsb_idx),
    .found_o (lsb_found)
  );

  assign hit_valid = (state_q == DRAIN);
  assign hit_qpos  = lsb_idx;
  assign hit_dpos  = dstart_q;
  assign hit_count = cnt_q;
  assign busy      = |pend_q;

  always_comb begin
    state_d  = state_q;
    query_d  = query_q;
    win_d    = win_q;
    fill_d   = fill_q;
    dcnt_d   = dcnt_q;
    dstart_d = dstart_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    db_ready = 1'b0;

    case (state_q)
      SCAN:    db_ready = 1'b1;
      // Accept only alongside the final pop so pend never holds two windows.
      DRAIN:   db_ready = pend_single && hit_ready;
      default: db_ready = 1'b0;
    endcase

    if (query_load) begin
      db_ready = 1'b0;
      query_d  = query;
      pend_d   = '0;
      win_d    = '0;
      fill_d   = '0;
      dcnt_d   = '0;
      cnt_d    = '0;
      state_d  = SCAN;
    end else if (state_q != NOQUERY) begin
      if (hit_valid && hit_ready) begin
        pend_d = pend_low_cleared;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      if (db_valid && db_ready) begin
        win_d  = win_shift;
        fill_d = fill_inc;
        dcnt_d = dcnt_q + DPOS_W'(1);
        if (fill_inc == FILL_W'(W)) begin
          pend_d   = cmp;
          dstart_d = dcnt_q - DPOS_W'(W - 1);
        end
        if (db_last) begin
          fill_d = '0;
          dcnt_d = '0;
        end
      end
      state_d = (pend_d != '0) ? DRAIN : SCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= NOQUERY;
      query_q  <= '0;
      win_q    <= '0;
      fill_q   <= '0;
      dcnt_q   <= '0;
      dstart_q <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      query_q  <= query_d;
      win_q    <= win_d;
      fill_q   <= fill_d;
      dcnt_q   <= dcnt_d;
      dstart_q <= dstart_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seed_hit_scanner.sv
// Bench for seed_hit_scanner: directed scenarios plus random traffic, all
// checked each cycle against a queue-based model of the expected hit list.
module tb_seed_hit_scanner;
  import seed_pkg::*;

  localparam int QB = 16;
  localparam int WW = 4;
  localparam int DW = 4;
  localparam int CW = 16;
  localparam int QW = 4;
  localparam int NP = QB - WW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*QB-1:0] query;
  logic          query_load;
  logic [1:0]    db_base;
  logic          db_valid;
  logic          db_ready;
  logic          db_last;
  logic          hit_valid;
  logic          hit_ready;
  logic [QW-1:0] hit_qpos;
  logic [DW-1:0] hit_dpos;
  logic [CW-1:0] hit_count;
  logic          busy;

  seed_hit_scanner #(
    .QUERY_BASES (QB),
    .W           (WW),
    .DPOS_W      (DW),
    .QPOS_W      (QW),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .query      (query),
    .query_load (query_load),
    .db_base    (db_base),
    .db_valid   (db_valid),
    .db_ready   (db_ready),
    .db_last    (db_last),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .hit_qpos   (hit_qpos),
    .hit_dpos   (hit_dpos),
    .hit_count  (hit_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the query as a base array, the bases of the current database
  // sequence, and the list of hits still owed to the downstream stage.
  bit        m_has_query;
  int        m_q [QB];
  int        m_seq [$];
  hit_pair_t m_hits [$];
  int        m_cnt;
  bit        last_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit model_ready(input bit ql, input bit hr);
    if (!m_has_query || ql) return 1'b0;
    if (m_hits.size() == 0) return 1'b1;
    return (m_hits.size() == 1) && hr;
  endfunction

  task automatic tick(input bit r, input bit ql, input bit dv, input logic [1:0] b,
                      input bit dl, input bit hr);
    bit        e_ready;
    int        dbefore;
    bit        match;
    hit_pair_t h;
    rst = r; query_load = ql; db_valid = dv; db_base = b; db_last = dl; hit_ready = hr;
    #1;
    e_ready    = model_ready(ql, hr);
    last_ready = db_ready;
    chk("db_ready", db_ready, e_ready);
    chk("hit_valid", hit_valid, m_hits.size() > 0);
    chk("busy", busy, m_hits.size() > 0);
    chk("hit_count", hit_count, m_cnt);
    if (m_hits.size() > 0) begin
      chk("hit_qpos", hit_qpos, m_hits[0].qpos);
      chk("hit_dpos", hit_dpos, m_hits[0].dpos);
    end
    @(posedge clk);
    if (r) begin
      m_has_query = 1'b0;
      m_hits.delete();
      m_seq.delete();
      m_cnt = 0;
    end else if (ql) begin
      for (int i = 0; i < QB; i++) m_q[i] = int'(query[2*i +: 2]);
      m_has_query = 1'b1;
      m_hits.delete();
      m_seq.delete();
      m_cnt = 0;
    end else if (m_has_query) begin
      if (m_hits.size() > 0 && hr) begin
        void'(m_hits.pop_front());
        if (m_cnt < 65535) m_cnt++;
      end
      if (dv && e_ready) begin
        dbefore = m_seq.size();
        m_seq.push_back(int'(b));
        if (m_seq.size() >= WW) begin
          for (int p = 0; p < NP; p++) begin
            match = 1'b1;
            for (int k = 0; k < WW; k++)
              if (m_q[p+k] != m_seq[m_seq.size()-WW+k]) match = 1'b0;
            if (match) begin
              h.qpos = 16'(p);
              h.dpos = 32'((dbefore - (WW - 1)) & ((1 << DW) - 1));
              m_hits.push_back(h);
            end
          end
        end
        if (dl) m_seq.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic feed(input logic [1:0] b, input bit dl);
    tick(1'b0, 1'b0, 1'b1, b, dl, 1'b1);
  endtask

  task automatic load_acgt();
    query = '1;
    query[1:0] = BASE_A; query[3:2] = BASE_C; query[5:4] = BASE_G; query[7:6] = BASE_T;
    tick(1'b0, 1'b1, 1'b0, BASE_A, 1'b0, 1'b1);
  endtask

  task automatic load_all_a();
    query = '0;
    tick(1'b0, 1'b1, 1'b0, BASE_A, 1'b0, 1'b1);
  endtask

  initial begin
    int lows;
    bit ql;
    rst = 1'b1; query = '0; query_load = 1'b0; db_base = BASE_A;
    db_valid = 1'b0; db_last = 1'b0; hit_ready = 1'b0;
    m_has_query = 1'b0; m_cnt = 0;
    @(negedge clk);

    // Reset with an offered beat, then no query loaded yet.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, BASE_A, 1'b0, 1'b1);
    chk("rst_qpos", hit_qpos, 0);
    chk("rst_dpos", hit_dpos, 0);
    chk("rst_count", hit_count, 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, BASE_A, 1'b0, 1'b1);
    chk("noquery_ready", last_ready, 0);

    // Single hit.
    load_acgt();
    feed(BASE_A, 0); feed(BASE_C, 0); feed(BASE_G, 0);
    tick(1'b0, 1'b0, 1'b1, BASE_T, 1'b0, 1'b0);
    chk("single_valid", hit_valid, 1);
    chk("single_qpos", hit_qpos, 0);
    chk("single_dpos", hit_dpos, 0);
    tick(1'b0, 1'b0, 1'b0, BASE_A, 1'b0, 1'b1);
    chk("single_count", hit_count, 1);

    // Multiple hits, ordered drain with a beat offered throughout.
    load_all_a();
    for (int i = 0; i < WW; i++) feed(BASE_A, 0);
    lows = 0;
    for (int i = 0; i < NP; i++) begin
      chk("multi_qpos", hit_qpos, i);
      feed(BASE_A, 0);
      if (!last_ready) lows++;
    end
    chk("multi_ready_lows", lows, NP - 1);
    chk("multi_last_ready", last_ready, 1);
    for (int i = 0; i < NP; i++) tick(1'b0, 1'b0, 1'b0, BASE_A, 1'b0, 1'b1);

    // Backpressure.
    feed(BASE_A, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b1, BASE_A, 1'b0, 1'b0);
      chk("bp_qpos", hit_qpos, 0);
      chk("bp_valid", hit_valid, 1);
    end
    for (int i = 0; i < NP; i++) begin
      chk("bp_resume_qpos", hit_qpos, i);
      tick(1'b0, 1'b0, 1'b0, BASE_A, 1'b0, 1'b1);
    end

    // Mid-drain query_load drops the offered beat.
    feed(BASE_A, 0);
    tick(1'b0, 1'b0, 1'b0, BASE_A, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, BASE_A, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1, BASE_A, 1'b0, 1'b1);
    chk("ql_ready", last_ready, 0);
    chk("ql_valid", hit_valid, 0);
    chk("ql_count", hit_count, 0);
    feed(BASE_A, 0);
    chk("ql_refill_valid", hit_valid, 0);

    // Sequence boundary.
    load_acgt();
    feed(BASE_A, 0); feed(BASE_C, 1); feed(BASE_G, 0); feed(BASE_T, 0);
    chk("bound_nohit", hit_valid, 0);
    feed(BASE_A, 0); feed(BASE_C, 0); feed(BASE_G, 0);
    tick(1'b0, 1'b0, 1'b1, BASE_T, 1'b0, 1'b0);
    chk("bound_valid", hit_valid, 1);
    chk("bound_dpos", hit_dpos, 2);
    tick(1'b0, 1'b0, 1'b0, BASE_A, 1'b0, 1'b1);

    // Position counter wrap.
    load_acgt();
    for (int i = 0; i < 14; i++) feed(BASE_A, 0);
    feed(BASE_A, 0); feed(BASE_C, 0); feed(BASE_G, 0);
    tick(1'b0, 1'b0, 1'b1, BASE_T, 1'b0, 1'b0);
    chk("wrap_qpos", hit_qpos, 0);
    chk("wrap_dpos", hit_dpos, 14);
    tick(1'b0, 1'b0, 1'b0, BASE_A, 1'b0, 1'b1);

    // Reset beats a simultaneous query_load.
    query = '0;
    tick(1'b1, 1'b1, 1'b1, BASE_A, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, BASE_A, 1'b0, 1'b1);
    chk("rst_wins_ready", last_ready, 0);

    // Random traffic over a mostly two-letter alphabet so hits are common.
    load_all_a();
    for (int c = 0; c < 3000; c++) begin
      ql = ($urandom_range(0, 149) == 0);
      if (ql) begin
        for (int i = 0; i < QB; i++)
          query[2*i +: 2] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3))
                                                         : 2'($urandom_range(0, 1));
      end
      tick($urandom_range(0, 999) == 0, ql, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 1)), $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
